// File: rtl/wt_dcache_rd_arb.sv
// wt_dcache_rd_arb
// Round-robin read arbiter in front of the dcache tag/data memories.
// A refill/write in progress (wr_busy_i) blocks every read port. A saturating
// counter flags ports that have been held off by wr_busy_i for too long.
//
// Ports
//   clk_i, rst_ni        clock, async active-low reset
//   wr_busy_i            write/refill owns the memories, blocks reads
//   rd_req_i             per-port read request
//   rd_tag_only_i        per-port tag-only lookup flag
//   rd_idx_i / rd_off_i  per-port cacheline index / byte offset
//   rd_tag_i             per-port tag, valid one cycle after that port's ack
//   rd_ack_o             per-port grant (one-hot or zero)
//   rd_req_o             request to cache memory
//   rd_ack_i             cache memory accepted the request this cycle
//   rd_idx_o / rd_off_o / rd_tag_only_o   winner's fields
//   rd_tag_o             tag of the port acked in the previous cycle
//   rd_starve_o          pending reads blocked for >= StarveLimit cycles
module wt_dcache_rd_arb #(
  parameter int unsigned NumPorts            = 3,
  parameter int unsigned StarveLimit         = 16,
  parameter int unsigned DCACHE_CL_IDX_WIDTH = 8,
  parameter int unsigned DCACHE_OFFSET_WIDTH = 4,
  parameter int unsigned DCACHE_TAG_WIDTH    = 12
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          wr_busy_i,
  input  logic [NumPorts-1:0]                           rd_req_i,
  input  logic [NumPorts-1:0]                           rd_tag_only_i,
  input  logic [NumPorts-1:0][DCACHE_CL_IDX_WIDTH-1:0]  rd_idx_i,
  input  logic [NumPorts-1:0][DCACHE_OFFSET_WIDTH-1:0]  rd_off_i,
  input  logic [NumPorts-1:0][DCACHE_TAG_WIDTH-1:0]     rd_tag_i,
  output logic [NumPorts-1:0]                           rd_ack_o,
  output logic                                          rd_req_o,
  input  logic                                          rd_ack_i,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]                rd_idx_o,
  output logic [DCACHE_OFFSET_WIDTH-1:0]                rd_off_o,
  output logic                                          rd_tag_only_o,
  output logic [DCACHE_TAG_WIDTH-1:0]                   rd_tag_o,
  output logic                                          rd_starve_o
);

  localparam int unsigned PtrW = $clog2(NumPorts);

  logic [PtrW-1:0] rr_ptr_q, grant_idx_q;
  logic [PtrW-1:0] win_idx;
  logic            win_vld;
  logic            grant;
  logic [7:0]      starve_cnt_q;

  // Scan from the farthest rotation offset down to offset 0 so the requester
  // closest to rr_ptr_q is the last one written and therefore wins. With no
  // requester win_idx stays at rr_ptr_q, which also drives the muxes below.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_ptr_q;
    for (int k = NumPorts - 1; k >= 0; k--) begin
      int unsigned s;
      s = int'(rr_ptr_q) + k;
      if (s >= NumPorts) s = s - NumPorts;
      if (rd_req_i[s]) begin
        win_vld = 1'b1;
        win_idx = PtrW'(s);
      end
    end
  end

  assign rd_req_o      = (|rd_req_i) & ~wr_busy_i;
  assign grant         = rd_req_o & rd_ack_i & win_vld;
  assign rd_idx_o      = rd_idx_i[win_idx];
  assign rd_off_o      = rd_off_i[win_idx];
  assign rd_tag_only_o = rd_tag_only_i[win_idx];
  // Tag arrives a cycle after its ack, so select it with the held grant index.
  assign rd_tag_o      = rd_tag_i[grant_idx_q];
  assign rd_starve_o   = (starve_cnt_q == 8'(StarveLimit));

  for (genvar p = 0; p < NumPorts; p++) begin : g_ack
    assign rd_ack_o[p] = grant & (win_idx == PtrW'(p));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else if (grant) begin
      rr_ptr_q    <= (win_idx == PtrW'(NumPorts - 1)) ? '0 : win_idx + PtrW'(1);
      grant_idx_q <= win_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else if ((|rd_req_i) & wr_busy_i) begin
      if (starve_cnt_q != 8'(StarveLimit)) starve_cnt_q <= starve_cnt_q + 8'd1;
    end else begin
      starve_cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Self-checking bench for wt_dcache_rd_arb: directed scenarios plus a random
// run, all compared against a queue-free behavioural model of the arbiter.
module tb_wt_dcache_rd_arb;
  localparam int NP  = 3;
  localparam int LIM = 16;

  logic             clk, rst_n;
  logic             wr_busy;
  logic [NP-1:0]    rd_req, rd_tag_only, rd_ack;
  logic [NP-1:0][7:0]  rd_idx;
  logic [NP-1:0][3:0]  rd_off;
  logic [NP-1:0][11:0] rd_tag;
  logic             mem_req, mem_ack;
  logic [7:0]       idx_o;
  logic [3:0]       off_o;
  logic             to_o;
  logic [11:0]      tag_o;
  logic             starve;

  int checks = 0;
  int errs   = 0;

  wt_dcache_rd_arb #(.NumPorts(NP), .StarveLimit(LIM), .DCACHE_CL_IDX_WIDTH(8),
                     .DCACHE_OFFSET_WIDTH(4), .DCACHE_TAG_WIDTH(12)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_busy_i(wr_busy), .rd_req_i(rd_req),
    .rd_tag_only_i(rd_tag_only), .rd_idx_i(rd_idx), .rd_off_i(rd_off),
    .rd_tag_i(rd_tag), .rd_ack_o(rd_ack), .rd_req_o(mem_req), .rd_ack_i(mem_ack),
    .rd_idx_o(idx_o), .rd_off_o(off_o), .rd_tag_only_o(to_o), .rd_tag_o(tag_o),
    .rd_starve_o(starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: priority pointer, last granted port, blocked-cycle count.
  int m_ptr, m_gidx, m_cnt;
  int e_win;
  logic [NP-1:0] e_ack;
  logic e_req, e_to, e_starve;
  logic [7:0] e_idx;
  logic [3:0] e_off;
  logic [11:0] e_tag;

  function automatic void model_eval();
    int sel;
    e_win = -1;
    for (int k = 0; k < NP; k++)
      if (e_win < 0 && rd_req[(m_ptr + k) % NP]) e_win = (m_ptr + k) % NP;
    sel      = (e_win < 0) ? m_ptr : e_win;
    e_req    = (rd_req != 0) && !wr_busy;
    e_ack    = (e_req && mem_ack) ? NP'(1 << e_win) : '0;
    e_idx    = rd_idx[sel];
    e_off    = rd_off[sel];
    e_to     = rd_tag_only[sel];
    e_tag    = rd_tag[m_gidx];
    e_starve = (m_cnt == LIM);
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_gidx = 0; m_cnt = 0;
  endfunction

  // Advance model with the inputs of the cycle just checked, then clock.
  task automatic tick();
    model_eval();
    if (e_ack != 0) begin
      m_gidx = e_win;
      m_ptr  = (e_win + 1) % NP;
    end
    if (rd_req != 0 && wr_busy) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
    else m_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic rand_fields();
    for (int p = 0; p < NP; p++) begin
      rd_idx[p] = 8'($urandom);
      rd_off[p] = 4'($urandom);
      rd_tag[p] = 12'($urandom);
    end
    rd_tag_only = NP'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_busy = 1'b0; mem_ack = 1'b1; rd_req = '0;
    rand_fields();
    model_reset();
    #2;
    model_eval();
    checks++; if (starve !== 1'b0) begin errs++; $display("FAIL reset_starve got=%b exp=0", starve); end
    checks++; if (tag_o !== rd_tag[0]) begin errs++; $display("FAIL reset_tag got=%h exp=%h", tag_o, rd_tag[0]); end
    checks++; if (idx_o !== rd_idx[0]) begin errs++; $display("FAIL reset_idx got=%h exp=%h", idx_o, rd_idx[0]); end
    checks++; if (rd_ack !== 3'b000 || mem_req !== 1'b0) begin errs++; $display("FAIL reset_idle ack=%b req=%b exp=000/0", rd_ack, mem_req); end
    // Combinational path works while reset is held, from reset register values.
    rd_req = 3'b010; #1;
    checks++; if (rd_ack !== 3'b010 || idx_o !== rd_idx[1]) begin errs++; $display("FAIL reset_comb ack=%b idx=%h exp=010/%h", rd_ack, idx_o, rd_idx[1]); end
    rd_req = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] exp_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rd_req = 3'b111; mem_ack = 1'b1; wr_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_fields(); #1; model_eval();
      checks++; if (rd_ack !== exp_seq[i]) begin errs++; $display("FAIL rr_seq[%0d] got=%b exp=%b", i, rd_ack, exp_seq[i]); end
      checks++; if (idx_o !== e_idx) begin errs++; $display("FAIL rr_idx[%0d] got=%h exp=%h", i, idx_o, e_idx); end
      tick();
    end
  endtask

  task automatic test_skip_idle_port();
    logic [NP-1:0] exp_seq [4] = '{3'b001, 3'b100, 3'b001, 3'b100};
    rd_req = 3'b101; mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (rd_ack !== exp_seq[i]) begin errs++; $display("FAIL skip_seq[%0d] got=%b exp=%b", i, rd_ack, exp_seq[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    // Pointer is 0 here; grant port 1, then port 2 while port 1's tag arrives.
    rd_req = 3'b010; mem_ack = 1'b1; #1;
    checks++; if (rd_ack !== 3'b010) begin errs++; $display("FAIL b2b_ack0 got=%b exp=010", rd_ack); end
    tick();
    rd_req = 3'b100; rd_tag[1] = 12'hABC; rd_idx[2] = 8'h5A; #1;
    checks++; if (tag_o !== 12'hABC) begin errs++; $display("FAIL b2b_tag got=%h exp=abc", tag_o); end
    checks++; if (idx_o !== 8'h5A) begin errs++; $display("FAIL b2b_idx got=%h exp=5a", idx_o); end
    checks++; if (rd_ack !== 3'b100) begin errs++; $display("FAIL b2b_ack1 got=%b exp=100", rd_ack); end
    tick();
    rd_tag[2] = 12'h123; #1;
    checks++; if (tag_o !== 12'h123) begin errs++; $display("FAIL b2b_tag2 got=%h exp=123", tag_o); end
  endtask

  task automatic test_starve();
    rd_req = 3'b010; wr_busy = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++; if (rd_ack !== 3'b000 || mem_req !== 1'b0) begin errs++; $display("FAIL starve_block[%0d] ack=%b req=%b", i, rd_ack, mem_req); end
      checks++; if (starve !== (i >= LIM)) begin errs++; $display("FAIL starve_flag[%0d] got=%b exp=%b", i, starve, i >= LIM); end
      tick();
    end
    wr_busy = 1'b0; #1;
    checks++; if (rd_ack !== 3'b010 || starve !== 1'b1) begin errs++; $display("FAIL starve_release ack=%b st=%b exp=010/1", rd_ack, starve); end
    tick();
    rd_req = '0; #1;
    checks++; if (starve !== 1'b0) begin errs++; $display("FAIL starve_clear got=%b exp=0", starve); end
    tick();
  endtask

  task automatic test_mem_busy();
    // Grant port 0 so port 1 heads the rotation.
    rd_req = 3'b001; mem_ack = 1'b1; tick();
    rd_req = 3'b110; mem_ack = 1'b0; rand_fields();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rd_ack !== 3'b000 || mem_req !== 1'b1) begin errs++; $display("FAIL mbusy_ack[%0d] ack=%b req=%b exp=000/1", i, rd_ack, mem_req); end
      checks++; if (idx_o !== rd_idx[1]) begin errs++; $display("FAIL mbusy_idx[%0d] got=%h exp=%h", i, idx_o, rd_idx[1]); end
      tick();
    end
    mem_ack = 1'b1; #1;
    checks++; if (rd_ack !== 3'b010) begin errs++; $display("FAIL mbusy_grant got=%b exp=010", rd_ack); end
    tick();
  endtask

  task automatic test_reset_mid();
    // Pointer now 2; also build up a starve indication before the reset.
    rd_req = 3'b010; wr_busy = 1'b1;
    repeat (LIM + 2) tick();
    #1;
    checks++; if (starve !== 1'b1) begin errs++; $display("FAIL rmid_pre_starve got=%b exp=1", starve); end
    rst_n = 1'b0; model_reset(); #1;
    checks++; if (starve !== 1'b0) begin errs++; $display("FAIL rmid_starve got=%b exp=0", starve); end
    @(negedge clk); rst_n = 1'b1; rd_req = 3'b111; wr_busy = 1'b0; mem_ack = 1'b1; #1;
    checks++; if (rd_ack !== 3'b001) begin errs++; $display("FAIL rmid_grant got=%b exp=001", rd_ack); end
    tick();
  endtask

  task automatic test_random();
    int busy_run = 0;
    for (int i = 0; i < 600; i++) begin
      if (busy_run == 0) begin
        busy_run = int'($urandom_range(1, 24));
        wr_busy  = ($urandom_range(0, 2) == 0);
      end
      busy_run--;
      rd_req  = ($urandom_range(0, 3) == 0) ? '0 : NP'($urandom);
      if (wr_busy && $urandom_range(0, 7) != 0) rd_req = 3'b001;
      mem_ack = ($urandom_range(0, 4) != 0);
      rand_fields();
      #1; model_eval();
      checks++; if (rd_ack !== e_ack) begin errs++; $display("FAIL rnd_ack[%0d] got=%b exp=%b", i, rd_ack, e_ack); end
      checks++; if (mem_req !== e_req) begin errs++; $display("FAIL rnd_req[%0d] got=%b exp=%b", i, mem_req, e_req); end
      checks++; if (idx_o !== e_idx || off_o !== e_off || to_o !== e_to) begin errs++;
        $display("FAIL rnd_fields[%0d] got=%h/%h/%b exp=%h/%h/%b", i, idx_o, off_o, to_o, e_idx, e_off, e_to); end
      checks++; if (tag_o !== e_tag) begin errs++; $display("FAIL rnd_tag[%0d] got=%h exp=%h", i, tag_o, e_tag); end
      checks++; if (starve !== e_starve) begin errs++; $display("FAIL rnd_starve[%0d] got=%b exp=%b", i, starve, e_starve); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_skip_idle_port();
    test_back_to_back();
    test_starve();
    test_mem_busy();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/wt_dcache_rd_arb.md
WT_DCACHE_RD_ARB -- requirements
Module: wt_dcache_rd_arb

Interface
REQ-001 Parameter: NumPorts, 3, number of read requesters; legal range 2..4.
REQ-002 Parameter: StarveLimit, 16, consecutive blocked cycles before rd_starve_o asserts; legal range 1..255.
REQ-003 Clock and reset: clk_i and rst_ni; one clock; reset is asynchronous and active-low.
REQ-004 clk_i  in  1  clock.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 wr_busy_i  in  1  write/refill path owns the tag/data memories; blocks all reads.
REQ-007 rd_req_i  in  NumPorts  per-port read request.
REQ-008 rd_tag_only_i  in  NumPorts  per-port tag-only lookup flag.
REQ-009 rd_idx_i  in  NumPorts x DCACHE_CL_IDX_WIDTH  per-port cacheline index.
REQ-010 rd_off_i  in  NumPorts x DCACHE_OFFSET_WIDTH  per-port byte offset.
REQ-011 rd_tag_i  in  NumPorts x DCACHE_TAG_WIDTH  per-port tag; valid one cycle after that port's ack.
REQ-012 rd_ack_o  out  NumPorts  per-port grant, one-hot or zero.
REQ-013 rd_req_o  out  1  request to cache memory.
REQ-014 rd_ack_i  in  1  cache memory accepted request this cycle.
REQ-015 rd_idx_o / rd_off_o / rd_tag_only_o  out  DCACHE_CL_IDX_WIDTH / DCACHE_OFFSET_WIDTH / 1  winner's fields.
REQ-016 rd_tag_o  out  DCACHE_TAG_WIDTH  tag of the port acked in the previous cycle.
REQ-017 rd_starve_o  out  1  pending reads blocked by wr_busy_i for >= StarveLimit cycles.

Function
REQ-018 Winner: first port p with rd_req_i[p]=1 scanning p = rr_ptr_q, rr_ptr_q+1, ... modulo NumPorts; no winner if rd_req_i all zero.
REQ-019 rd_req_o = (|rd_req_i) & ~wr_busy_i, combinational.
REQ-020 rd_idx_o, rd_off_o, rd_tag_only_o = winner's inputs, combinational; when no winner they are port rr_ptr_q's inputs.
REQ-021 rd_ack_o[winner] = rd_ack_i & rd_req_o; all other bits 0; rd_ack_o all 0 whenever wr_busy_i=1.
REQ-022 rr_ptr_q updates only on a granted cycle: rr_ptr_q <= (winner+1) mod NumPorts; wraps NumPorts-1 -> 0; unchanged otherwise.
REQ-023 A port requesting without ack keeps priority position; rd_req_i deassertion before ack is legal and drops the request without state change.
REQ-024 grant_idx_q <= winner on every granted cycle; held otherwise; rd_tag_o = rd_tag_i[grant_idx_q] combinationally (zero-latency mux, one-cycle-later tag timing).
REQ-025 Back-to-back grants to different ports: tag of cycle-N grant appears on rd_tag_o in cycle N+1 while cycle N+1 winner's index is presented.
REQ-026 Starvation counter starve_cnt_q (8 bit): increments, saturating at StarveLimit, each cycle with |rd_req_i & wr_busy_i; clears to 0 on any cycle with wr_busy_i=0 or no request.
REQ-027 rd_starve_o = (starve_cnt_q == StarveLimit), registered; deasserts the cycle after the clearing condition.
REQ-028 rd_ack_i=0 with rd_req_o=1 (memory busy): no grant, rr_ptr_q and grant_idx_q hold, starve counter not affected.
REQ-029 Maximum latency for a continuously requesting port with wr_busy_i=0 and rd_ack_i=1: NumPorts-1 grants to other ports.

Reset
REQ-030 On rst_ni=0: rr_ptr_q=0, grant_idx_q=0, starve_cnt_q=0, rd_starve_o=0, asynchronously.
REQ-031 During and after reset, combinational outputs follow REQ-019..REQ-024 using reset register values; rd_tag_o = rd_tag_i[0].
REQ-032 Reset asserted mid-sequence discards all arbitration history; first grant after reset goes to lowest-index requesting port.

Verification
REQ-033 After reset, rd_req_i=3'b111, rd_ack_i=1 for 6 cycles -> rd_ack_o = 001,010,100,001,010,100.
REQ-034 rd_req_i=3'b101, rd_ack_i=1 -> grants alternate 001,100,001; port 1 never acked; rr_ptr wraps 2->0 (via 0+1->... then 2+1=0).
REQ-035 Port 1 acked in cycle N with rd_tag_i[1]=0xABC in cycle N+1, port 2 acked in N+1 -> rd_tag_o=0xABC in N+1, rd_idx_o = rd_idx_i[2] in N+1.
REQ-036 wr_busy_i=1, rd_req_i=3'b010 for 20 cycles, StarveLimit=16 -> rd_ack_o=0 throughout, rd_starve_o rises after 16 blocked cycles, falls one cycle after wr_busy_i drops; port 1 acked first cycle wr_busy_i=0.
REQ-037 rd_ack_i=0 for 3 cycles with rd_req_i=3'b110 -> no ack, rd_idx_o steady = rd_idx_i[1]; on rd_ack_i=1 port 1 acked.
REQ-038 rst_ni pulsed low with rr_ptr_q=2 -> next grant with rd_req_i=3'b111 goes to port 0, rd_starve_o=0.
